// File: rtl/mips_top.sv
// mips_top: single-cycle 32-bit MIPS subset processor with its instruction and data memories.
// One instruction is fetched, decoded, executed and retired on every rising clock edge.
//
// Ports:
//   clk        rising-edge clock for PC, register file and data memory
//   rst        asynchronous active-high reset, clears the PC only
//   writedata  register rt value presented to data memory (store data)
//   readdata   data memory read data at dataadr
//   dataadr    ALU result, used as the data memory byte address
//   memwrite   high during a sw instruction
//   instr      instruction currently fetched at PC
//
// Supported: add, sub, and, or, slt, addi, ori, lui, lw, sw, beq, j.
// Memories index with address bits [7:2], so addresses alias modulo 256 bytes.

// 64-word instruction memory. The write port is tied off at the top level; programs are
// preloaded into RAM before reset is released.
module mips_imem (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [5:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] RAM [0:63];

    always_ff @(posedge i_clk) begin
        if (i_we) RAM[i_addr] <= i_wdata;
    end

    assign o_rdata = RAM[i_addr];
endmodule

// 64-word data memory: combinational read, write on the rising edge.
module mips_dmem (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [5:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] RAM [0:63];

    always_ff @(posedge i_clk) begin
        if (i_we) RAM[i_addr] <= i_wdata;
    end

    assign o_rdata = RAM[i_addr];
endmodule

// 32x32 register file: two combinational read ports, one write port. $0 reads as zero and
// writes to it are dropped, so rf[0] is never modified.
module mips_regfile (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] rf [0:31];

    always_ff @(posedge i_clk) begin
        if (i_we && (i_wa != 5'd0)) rf[i_wa] <= i_wd;
    end

    assign o_rd1 = (i_ra1 != 5'd0) ? rf[i_ra1] : 32'd0;
    assign o_rd2 = (i_ra2 != 5'd0) ? rf[i_ra2] : 32'd0;
endmodule

// Datapath: PC register, register file, immediate generation, ALU and next-PC selection.
// Takes the low 26 instruction bits; the opcode/funct are decoded by the controller.
module mips_datapath (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [25:0] i_instr,
    input  logic [31:0] i_readdata,
    input  logic        i_regwrite,
    input  logic        i_regdst,
    input  logic        i_alusrc,
    input  logic        i_memtoreg,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic [1:0]  i_immsel,
    input  logic [2:0]  i_aluctl,
    output logic [31:0] o_pc,
    output logic [31:0] o_aluout,
    output logic [31:0] o_writedata
);
    logic [31:0] pc;
    logic [31:0] w_pcplus4, w_pcbranch, w_pcnext;
    logic [31:0] w_srca, w_srcb, w_imm, w_signimm, w_result;
    logic [4:0]  w_wa;

    assign w_signimm = {{16{i_instr[15]}}, i_instr[15:0]};

    always_comb begin
        unique case (i_immsel)
            2'd1:    w_imm = {16'd0, i_instr[15:0]};
            2'd2:    w_imm = {i_instr[15:0], 16'd0};
            default: w_imm = w_signimm;
        endcase
    end

    assign w_wa = i_regdst ? i_instr[15:11] : i_instr[20:16];
    assign w_result = i_memtoreg ? i_readdata : o_aluout;

    mips_regfile rf (
        .i_clk (i_clk),
        .i_we  (i_regwrite),
        .i_ra1 (i_instr[25:21]),
        .i_ra2 (i_instr[20:16]),
        .i_wa  (w_wa),
        .i_wd  (w_result),
        .o_rd1 (w_srca),
        .o_rd2 (o_writedata)
    );

    assign w_srcb = i_alusrc ? w_imm : o_writedata;

    // ALU codes: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 pass B (lui).
    always_comb begin
        case (i_aluctl)
            3'd1:    o_aluout = w_srca - w_srcb;
            3'd2:    o_aluout = w_srca & w_srcb;
            3'd3:    o_aluout = w_srca | w_srcb;
            3'd4:    o_aluout = {31'd0, $signed(w_srca) < $signed(w_srcb)};
            3'd5:    o_aluout = w_srcb;
            default: o_aluout = w_srca + w_srcb;
        endcase
    end

    assign w_pcplus4  = pc + 32'd4;
    assign w_pcbranch = w_pcplus4 + {w_signimm[29:0], 2'b00};

    always_comb begin
        w_pcnext = w_pcplus4;
        if (i_jump)                                     w_pcnext = {w_pcplus4[31:28], i_instr, 2'b00};
        else if (i_branch && (w_srca == o_writedata))   w_pcnext = w_pcbranch;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) pc <= 32'd0;
        else       pc <= w_pcnext;
    end

    assign o_pc = pc;
endmodule

// Core: main decoder plus datapath.
module mips_core (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_readdata,
    output logic [31:0] o_pc,
    output logic        o_memwrite,
    output logic [31:0] o_aluout,
    output logic [31:0] o_writedata
);
    logic       w_regwrite, w_regdst, w_alusrc, w_memtoreg, w_branch, w_jump;
    logic [1:0] w_immsel;
    logic [2:0] w_aluctl;

    always_comb begin
        w_regwrite = 1'b0;
        w_regdst   = 1'b0;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_branch   = 1'b0;
        w_jump     = 1'b0;
        o_memwrite = 1'b0;
        w_immsel   = 2'd0;
        w_aluctl   = 3'd0;
        case (i_instr[31:26])
            6'h00: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                case (i_instr[5:0])
                    6'h20:   w_aluctl = 3'd0;
                    6'h22:   w_aluctl = 3'd1;
                    6'h24:   w_aluctl = 3'd2;
                    6'h25:   w_aluctl = 3'd3;
                    6'h2A:   w_aluctl = 3'd4;
                    default: w_regwrite = 1'b0;
                endcase
            end
            6'h08: begin w_regwrite = 1'b1; w_alusrc = 1'b1; end
            6'h0D: begin
                w_regwrite = 1'b1; w_alusrc = 1'b1; w_immsel = 2'd1; w_aluctl = 3'd3;
            end
            6'h0F: begin
                w_regwrite = 1'b1; w_alusrc = 1'b1; w_immsel = 2'd2; w_aluctl = 3'd5;
            end
            6'h23: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_memtoreg = 1'b1; end
            6'h2B: begin w_alusrc = 1'b1; o_memwrite = 1'b1; end
            6'h04: begin w_branch = 1'b1; w_aluctl = 3'd1; end
            6'h02: w_jump = 1'b1;
            default: ;
        endcase
    end

    mips_datapath dp (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_instr     (i_instr[25:0]),
        .i_readdata  (i_readdata),
        .i_regwrite  (w_regwrite),
        .i_regdst    (w_regdst),
        .i_alusrc    (w_alusrc),
        .i_memtoreg  (w_memtoreg),
        .i_branch    (w_branch),
        .i_jump      (w_jump),
        .i_immsel    (w_immsel),
        .i_aluctl    (w_aluctl),
        .o_pc        (o_pc),
        .o_aluout    (o_aluout),
        .o_writedata (o_writedata)
    );
endmodule

module mips_top (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] dataadr,
    output logic        memwrite,
    output logic [31:0] instr
);
    logic [31:0] w_pc;
    logic        w_unused_pc;

    // Only word-index bits of the PC reach instruction memory.
    assign w_unused_pc = ^{w_pc[31:8], w_pc[1:0]};

    mips_core mips (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_instr     (instr),
        .i_readdata  (readdata),
        .o_pc        (w_pc),
        .o_memwrite  (memwrite),
        .o_aluout    (dataadr),
        .o_writedata (writedata)
    );

    mips_imem imem (
        .i_clk   (clk),
        .i_we    (1'b0),
        .i_addr  (w_pc[7:2]),
        .i_wdata (32'd0),
        .o_rdata (instr)
    );

    mips_dmem dmem (
        .i_clk   (clk),
        .i_we    (memwrite),
        .i_addr  (dataadr[7:2]),
        .i_wdata (writedata),
        .o_rdata (readdata)
    );
endmodule

// File: tb/tb_mips_top.sv
// tb_mips_top: directed program for mips_top. Expected values are queued when the stimulus
// is set up and popped when the corresponding DUT value is sampled, 1 ps after a clock edge.
`timescale 1ps/1ps

module tb_mips_top;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] writedata, readdata, dataadr, instr;
    logic        memwrite;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mips_top dut (
        .clk       (clk),
        .rst       (rst),
        .writedata (writedata),
        .readdata  (readdata),
        .dataadr   (dataadr),
        .memwrite  (memwrite),
        .instr     (instr)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
            return;
        end
        e = q.pop_front();
        assert (obs === e.val) n_pass++;
        else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prog [0:15];

    initial begin
        prog[0]  = 32'h3C080001; // lui  $8,1
        prog[1]  = 32'h01084020; // add  $8,$8,$8
        prog[2]  = 32'h200A0005; // addi $10,$0,5
        prog[3]  = 32'h200BFFFD; // addi $11,$0,-3
        prog[4]  = 32'h014B5022; // sub  $10,$10,$11
        prog[5]  = 32'h016A602A; // slt  $12,$11,$10
        prog[6]  = 32'h20020044; // addi $2,$0,0x44
        prog[7]  = 32'hAC020004; // sw   $2,4($0)
        prog[8]  = 32'h8C030004; // lw   $3,4($0)
        prog[9]  = 32'h10000001; // beq  $0,$0,+1
        prog[10] = 32'h200D0001; // addi $13,$0,1 (skipped)
        prog[11] = 32'h200E0002; // addi $14,$0,2
        prog[12] = 32'h20000007; // addi $0,$0,7
        prog[13] = 32'h340FF0F0; // ori  $15,$0,0xF0F0
        prog[14] = 32'hAC000008; // sw   $0,8($0)
        prog[15] = 32'h08000000; // j    0
        for (int i = 0; i < 64; i++) dut.imem.RAM[i] = (i < 16) ? prog[i] : 32'd0;

        #1 rst = 1'b1;
        #1;
        push("reset_pc", 32'd0);          pop_check(dut.mips.dp.pc);
        push("reset_instr", 32'h3C080001); pop_check(instr);
        #29 rst = 1'b0;                   // released at t=31; next edge at t=35

        push("lui_r8", 32'h00010000);     step(); pop_check(dut.mips.dp.rf.rf[8]);
        push("add_r8", 32'h00020000);     step(); pop_check(dut.mips.dp.rf.rf[8]);
        step(); step();
        push("addi_neg_r11", 32'hFFFFFFFD); pop_check(dut.mips.dp.rf.rf[11]);
        push("sub_r10", 32'd8);           step(); pop_check(dut.mips.dp.rf.rf[10]);
        push("slt_r12", 32'd1);           step(); pop_check(dut.mips.dp.rf.rf[12]);
        step();                           // addi $2; now at sw
        push("sw_memwrite", 32'd1);       pop_check({31'd0, memwrite});
        push("sw_dataadr", 32'd4);        pop_check(dataadr);
        push("sw_writedata", 32'h44);     pop_check(writedata);
        push("dmem_word1", 32'h44);       step(); pop_check(dut.dmem.RAM[1]);
        push("lw_readdata", 32'h44);      pop_check(readdata);
        push("lw_memwrite", 32'd0);       pop_check({31'd0, memwrite});
        push("lw_r3", 32'h44);            step(); pop_check(dut.mips.dp.rf.rf[3]);
        push("beq_taken_pc", 32'h2C);     step(); pop_check(dut.mips.dp.pc);
        push("addi_r14", 32'd2);          step(); pop_check(dut.mips.dp.rf.rf[14]);
        push("addi_r0_dataadr", 32'd7);   pop_check(dataadr);
        push("r0_unchanged", 32'd0);      step(); pop_check(dut.mips.dp.rf.rf[0]);
        push("ori_zext_r15", 32'h0000F0F0); step(); pop_check(dut.mips.dp.rf.rf[15]);
        push("sw_r0_writedata", 32'd0);   pop_check(writedata);
        push("sw_r0_dataadr", 32'd8);     pop_check(dataadr);
        step();                           // sw $0; now at j
        push("j_pc", 32'd0);              step(); pop_check(dut.mips.dp.pc);
        push("j_instr", 32'h3C080001);    pop_check(instr);
        step(); step();
        push("run_pc", 32'd8);            pop_check(dut.mips.dp.pc);

        // Mid-cycle reset: PC must clear before the next rising edge.
        #2 rst = 1'b1;
        #1;
        push("async_rst_pc", 32'd0);      pop_check(dut.mips.dp.pc);
        push("async_rst_instr", 32'h3C080001); pop_check(instr);
        #2 rst = 1'b0;
        push("after_rst_pc", 32'd4);      step(); pop_check(dut.mips.dp.pc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
